// File: rtl/pipeline_pkg.sv
// Shared types and constants for the F/D/EW pipeline hazard controller.
package pipeline_pkg;
  localparam int REG_ADDR_W = 3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_E  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } hz_state_t;
endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding mux select: Execute ALU result beats Writeback, else regfile.
// Purely combinational; loads in Execute are not forwardable from E.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic [1:0]            write_mode_E,
  input  logic                  mem_read_E,
  input  logic [REG_ADDR_W-1:0] rd_W,
  input  logic [1:0]            write_mode_W,
  output logic [1:0]            sel
);
  always_comb begin
    sel = FWD_RF;
    if (write_mode_E != 2'b00 && !mem_read_E && rd_E == rs) begin
      sel = FWD_E;
    end else if (write_mode_W != 2'b00 && rd_W == rs) begin
      sel = FWD_W;
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding and memory watchdog.
// Optional perf counters (stall_cycles, flush_events) under HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int BR_EXTRA    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic                  use_rs1_D,
  input  logic                  use_rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic [1:0]            write_mode_E,
  input  logic                  mem_read_E,
  input  logic [REG_ADDR_W-1:0] rd_W,
  input  logic [1:0]            write_mode_W,
  input  logic                  mem_access_W,
  input  logic                  mem_ready,
  input  logic                  branch_taken_E,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  stall_E,
  output logic                  flush_F,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
`ifdef HAZARD_PERF_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events,
`endif
  output logic                  busy,
  output logic                  mem_err
);
  localparam logic [7:0] TIMEOUT_V = MEM_TIMEOUT[7:0];
  localparam logic [1:0] BR_EXTRA_V = BR_EXTRA[1:0];

  hz_state_t  state, next_state;
  logic [1:0] br_cnt, br_cnt_nxt;
  logic [7:0] wd_cnt;

  logic mem_wait_cond, load_use, branch_accept;
  logic stall_f_raw, stall_d_raw, stall_e_raw;
  logic flush_f_raw, flush_d_raw, flush_e_raw;

  assign mem_wait_cond = mem_access_W && !mem_ready;
  assign load_use = mem_read_E && (write_mode_E != 2'b00) &&
                    ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));

  always_comb begin
    next_state    = state;
    br_cnt_nxt    = br_cnt;
    branch_accept = 1'b0;
    stall_f_raw   = 1'b0;
    stall_d_raw   = 1'b0;
    stall_e_raw   = 1'b0;
    flush_f_raw   = 1'b0;
    flush_d_raw   = 1'b0;
    flush_e_raw   = 1'b0;
    if (mem_wait_cond) begin
      stall_f_raw = 1'b1;
      stall_d_raw = 1'b1;
      stall_e_raw = 1'b1;
      next_state  = MEM_WAIT;
    end else if (state == MEM_WAIT) begin
      // Completion cycle: release only; a held branch is acted on next cycle in RUN.
      next_state = RUN;
      br_cnt_nxt = 2'd0;
    end else if (branch_taken_E) begin
      flush_f_raw   = 1'b1;
      flush_d_raw   = 1'b1;
      branch_accept = 1'b1;
      if (BR_EXTRA_V != 2'd0) begin
        next_state = BR_FLUSH;
        br_cnt_nxt = BR_EXTRA_V;
      end else begin
        next_state = RUN;
        br_cnt_nxt = 2'd0;
      end
    end else begin
      if (state == BR_FLUSH) begin
        flush_f_raw = 1'b1;
        if (br_cnt <= 2'd1) begin
          next_state = RUN;
          br_cnt_nxt = 2'd0;
        end else begin
          br_cnt_nxt = br_cnt - 2'd1;
        end
      end
      if (load_use) begin
        stall_f_raw = 1'b1;
        flush_d_raw = 1'b1;
      end
    end
  end

  // A flushed register must not also be held.
  assign flush_F = flush_f_raw;
  assign flush_D = flush_d_raw;
  assign flush_E = flush_e_raw;
  assign stall_F = stall_f_raw && !flush_f_raw;
  assign stall_D = stall_d_raw && !flush_d_raw;
  assign stall_E = stall_e_raw && !flush_e_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      br_cnt  <= 2'd0;
      busy    <= 1'b0;
      wd_cnt  <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state  <= next_state;
      br_cnt <= br_cnt_nxt;
      busy   <= (next_state != RUN);
      if (state != MEM_WAIT && next_state == MEM_WAIT) begin
        wd_cnt <= 8'd0;
      end else if (state == MEM_WAIT && mem_wait_cond && wd_cnt != TIMEOUT_V) begin
        wd_cnt <= wd_cnt + 8'd1;
        if (wd_cnt + 8'd1 == TIMEOUT_V) begin
          mem_err <= 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (stall_F && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (branch_accept && flush_events != 16'hFFFF) begin
        flush_events <= flush_events + 16'd1;
      end
    end
  end
`endif

  fwd_select u_fwd_a (
    .rs           (rs1_D),
    .rd_E         (rd_E),
    .write_mode_E (write_mode_E),
    .mem_read_E   (mem_read_E),
    .rd_W         (rd_W),
    .write_mode_W (write_mode_W),
    .sel          (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .rs           (rs2_D),
    .rd_E         (rd_E),
    .write_mode_E (write_mode_E),
    .mem_read_E   (mem_read_E),
    .rd_W         (rd_W),
    .write_mode_W (write_mode_W),
    .sel          (fwd_b_sel)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (BR_EXTRA=1, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rs1_D, rs2_D, rd_E, rd_W;
  logic       use_rs1_D, use_rs2_D, mem_read_E, mem_access_W, mem_ready, branch_taken_E;
  logic [1:0] write_mode_E, write_mode_W;
  logic       stall_F, stall_D, stall_E, flush_F, flush_D, flush_E, busy, mem_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif
  logic [5:0] ctl;
  int total = 0;
  int bad = 0;

  // ctl = {stall_F, stall_D, stall_E, flush_F, flush_D, flush_E}
  assign ctl = {stall_F, stall_D, stall_E, flush_F, flush_D, flush_E};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .BR_EXTRA(1)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .rd_E(rd_E), .write_mode_E(write_mode_E), .mem_read_E(mem_read_E),
    .rd_W(rd_W), .write_mode_W(write_mode_W), .mem_access_W(mem_access_W),
    .mem_ready(mem_ready), .branch_taken_E(branch_taken_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_F(flush_F), .flush_D(flush_D), .flush_E(flush_E),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .busy(busy), .mem_err(mem_err)
  );

  task automatic idle();
    rs1_D = 3'd1; rs2_D = 3'd1; use_rs1_D = 1'b0; use_rs2_D = 1'b0;
    rd_E = 3'd5; write_mode_E = 2'b00; mem_read_E = 1'b0;
    rd_W = 3'd6; write_mode_W = 2'b00; mem_access_W = 1'b0;
    mem_ready = 1'b0; branch_taken_E = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL rst_ctl got=%b exp=000000", ctl); end
    total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin bad++; $display("FAIL rst_fwd got=%b/%b exp=00/00", fwd_a_sel, fwd_b_sel); end
    total++; if (busy !== 1'b0 || mem_err !== 1'b0) begin bad++; $display("FAIL rst_regs busy=%b mem_err=%b exp=0/0", busy, mem_err); end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    idle();
    mem_read_E = 1'b1; rd_E = 3'd3; write_mode_E = 2'b01; rs1_D = 3'd3; use_rs1_D = 1'b1;
    #1;
    total++; if (ctl !== 6'b100010) begin bad++; $display("FAIL lu_rs1 got=%b exp=100010", ctl); end
    total++; if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL lu_nofwdE got=%b exp=00", fwd_a_sel); end
    step();
    idle();
    #1;
    total++; if (ctl !== 6'b000000 || busy !== 1'b0) begin bad++; $display("FAIL lu_one_cycle ctl=%b busy=%b exp=000000/0", ctl, busy); end
    mem_read_E = 1'b1; rd_E = 3'd4; write_mode_E = 2'b10; rs2_D = 3'd4; use_rs2_D = 1'b1;
    #1;
    total++; if (ctl !== 6'b100010) begin bad++; $display("FAIL lu_rs2 got=%b exp=100010", ctl); end
    use_rs2_D = 1'b0;
    #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL lu_unused got=%b exp=000000", ctl); end
    use_rs2_D = 1'b1; write_mode_E = 2'b00;
    #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL lu_nowrite got=%b exp=000000", ctl); end
    step();
  endtask

  task automatic test_forward();
    idle();
    rd_E = 3'd2; rd_W = 3'd2; rs2_D = 3'd2; write_mode_E = 2'b01; write_mode_W = 2'b01;
    #1;
    total++; if (fwd_b_sel !== 2'b10) begin bad++; $display("FAIL fwd_b_E got=%b exp=10", fwd_b_sel); end
    write_mode_E = 2'b00;
    #1;
    total++; if (fwd_b_sel !== 2'b01) begin bad++; $display("FAIL fwd_b_W got=%b exp=01", fwd_b_sel); end
    write_mode_W = 2'b00;
    #1;
    total++; if (fwd_b_sel !== 2'b00) begin bad++; $display("FAIL fwd_b_RF got=%b exp=00", fwd_b_sel); end
    rd_E = 3'd0; rs1_D = 3'd0; write_mode_E = 2'b11;
    #1;
    total++; if (fwd_a_sel !== 2'b10) begin bad++; $display("FAIL fwd_a_r0 got=%b exp=10", fwd_a_sel); end
    mem_read_E = 1'b1; rd_W = 3'd0; write_mode_W = 2'b10;
    #1;
    total++; if (fwd_a_sel !== 2'b01) begin bad++; $display("FAIL fwd_a_load got=%b exp=01", fwd_a_sel); end
    step();
    idle();
  endtask

  task automatic test_branch();
    idle();
    branch_taken_E = 1'b1;
    #1;
    total++; if (ctl !== 6'b000110 || busy !== 1'b0) begin bad++; $display("FAIL br_c1 ctl=%b busy=%b exp=000110/0", ctl, busy); end
    step();
    branch_taken_E = 1'b0;
    #1;
    total++; if (ctl !== 6'b000100 || busy !== 1'b1) begin bad++; $display("FAIL br_c2 ctl=%b busy=%b exp=000100/1", ctl, busy); end
    step();
    total++; if (ctl !== 6'b000000 || busy !== 1'b0) begin bad++; $display("FAIL br_done ctl=%b busy=%b exp=000000/0", ctl, busy); end
    branch_taken_E = 1'b1;
    step();
    #1;
    total++; if (ctl !== 6'b000110) begin bad++; $display("FAIL br_restart got=%b exp=000110", ctl); end
    step();
    branch_taken_E = 1'b0;
    mem_read_E = 1'b1; rd_E = 3'd3; write_mode_E = 2'b01; rs1_D = 3'd3; use_rs1_D = 1'b1;
    #1;
    total++; if (ctl !== 6'b000110) begin bad++; $display("FAIL br_lu_flushwins got=%b exp=000110", ctl); end
    step();
    idle();
    #1;
    total++; if (ctl !== 6'b000000 || busy !== 1'b0) begin bad++; $display("FAIL br_restart_done ctl=%b busy=%b exp=000000/0", ctl, busy); end
  endtask

  task automatic test_mem_wait();
    idle();
    mem_access_W = 1'b1; mem_ready = 1'b1;
    #1;
    total++; if (ctl !== 6'b000000) begin bad++; $display("FAIL mw_sameready got=%b exp=000000", ctl); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mw_sameready_busy got=%b exp=0", busy); end
    mem_ready = 1'b0; branch_taken_E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== 6'b111000) begin bad++; $display("FAIL mw_stall%0d got=%b exp=111000", i, ctl); end
      total++; if (busy !== (i > 0)) begin bad++; $display("FAIL mw_busy%0d got=%b exp=%b", i, busy, (i > 0)); end
      step();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (ctl !== 6'b000000 || busy !== 1'b1) begin bad++; $display("FAIL mw_ready ctl=%b busy=%b exp=000000/1", ctl, busy); end
    step();
    mem_access_W = 1'b0; mem_ready = 1'b0;
    #1;
    total++; if (ctl !== 6'b000110 || busy !== 1'b0) begin bad++; $display("FAIL mw_branch ctl=%b busy=%b exp=000110/0", ctl, busy); end
    step();
    branch_taken_E = 1'b0;
    #1;
    total++; if (ctl !== 6'b000100) begin bad++; $display("FAIL mw_brflush got=%b exp=000100", ctl); end
    step();
    total++; if (ctl !== 6'b000000 || mem_err !== 1'b0) begin bad++; $display("FAIL mw_end ctl=%b mem_err=%b exp=000000/0", ctl, mem_err); end
  endtask

  task automatic test_timeout();
    idle();
    mem_access_W = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      total++; if (mem_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_wait%0d mem_err=%b busy=%b exp=0/1", k, mem_err, busy); end
      step();
    end
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_set got=%b exp=1", mem_err); end
    repeat (5) step();
    total++; if (mem_err !== 1'b1 || ctl !== 6'b111000) begin bad++; $display("FAIL to_sticky mem_err=%b ctl=%b exp=1/111000", mem_err, ctl); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (mem_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_reset mem_err=%b busy=%b exp=0/0", mem_err, busy); end
    idle();
    reset = 1'b0;
    step();
    total++; if (ctl !== 6'b000000 || busy !== 1'b0) begin bad++; $display("FAIL to_run ctl=%b busy=%b exp=000000/0", ctl, busy); end
    branch_taken_E = 1'b1;
    step();
    branch_taken_E = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (ctl !== 6'b000000 || busy !== 1'b0) begin bad++; $display("FAIL rst_brflush ctl=%b busy=%b exp=000000/0", ctl, busy); end
    reset = 1'b0;
    step();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    mem_read_E = 1'b1; rd_E = 3'd3; write_mode_E = 2'b01; rs1_D = 3'd3; use_rs1_D = 1'b1;
    repeat (3) step();
    idle();
    for (int b = 0; b < 2; b++) begin
      branch_taken_E = 1'b1;
      step();
      branch_taken_E = 1'b0;
      step();
      step();
    end
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
    total++; if (flush_events !== 16'd2) begin bad++; $display("FAIL perf_flush got=%0d exp=2", flush_events); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
